// File: rtl/cache_tag_nway.sv
// N-way set-associative tag store with tree-PLRU replacement and dirty tracking.
// A set-by-set invalidate sweep runs after reset and whenever inv_all is raised.
module cache_tag_nway #(
    parameter int WAYS     = 4,
    parameter int INDEX_W  = 7,
    parameter int OFFSET_W = 5
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     cached,
    input  logic                     sram_en,
    input  logic [3:0]               sram_wen,
    input  logic [31:0]              sram_addr,
    input  logic                     refresh,
    input  logic                     inv_all,
    output logic [WAYS-1:0]          hit,
    output logic                     miss,
    output logic                     stallreq,
    output logic [$clog2(WAYS)-1:0]  victim,
    output logic                     write_back,
    output logic [31:0]              axi_raddr,
    output logic [31:0]              axi_waddr,
    output logic                     busy
);

    localparam int TAG_W = 32 - INDEX_W - OFFSET_W;
    localparam int SETS  = 1 << INDEX_W;
    localparam int VW    = $clog2(WAYS);
    localparam int PW    = WAYS - 1;
    localparam logic [INDEX_W-1:0] CNT_ONE = {{(INDEX_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {ST_SWEEP = 1'b0, ST_IDLE = 1'b1} state_t;

    // Tree PLRU: bit0 picks the half, bit1/bit2 pick the way inside it.
    function automatic logic [1:0] plru_victim(input logic [PW-1:0] p);
        logic [2:0] q;
        q = 3'(p);
        if (WAYS == 2)  plru_victim = {1'b0, q[0]};
        else if (q[0])  plru_victim = {1'b1, q[2]};
        else            plru_victim = {1'b0, q[1]};
    endfunction

    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] p, input logic [1:0] way);
        logic [2:0] q;
        q = 3'(p);
        if (WAYS == 2) begin
            q[0] = ~way[0];
        end else if (way[1]) begin
            q[0] = 1'b0;
            q[2] = ~way[0];
        end else begin
            q[0] = 1'b1;
            q[1] = ~way[0];
        end
        plru_touch = PW'(q);
    endfunction

    state_t              r_state, w_state_nxt;
    logic [INDEX_W-1:0]  r_sweep_cnt, w_sweep_nxt;

    logic [WAYS-1:0]     r_valid [SETS];
    logic [WAYS-1:0]     r_dirty [SETS];
    logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
    logic [PW-1:0]       r_plru  [SETS];

    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    logic                w_busy, w_active, w_miss;
    logic [WAYS-1:0]     w_hit;
    logic [VW-1:0]       w_hit_way, w_victim;

    assign w_index = sram_addr[OFFSET_W +: INDEX_W];
    assign w_tag   = sram_addr[31 -: TAG_W];

    // State register and sweep counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_SWEEP;
            r_sweep_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_cnt <= w_sweep_nxt;
        end
    end

    // Next-state logic: sweep runs to the last set; inv_all only honoured when idle
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep_cnt;
        case (r_state)
            ST_SWEEP: begin
                w_sweep_nxt = r_sweep_cnt + CNT_ONE;
                if (r_sweep_cnt == {INDEX_W{1'b1}}) w_state_nxt = ST_IDLE;
                else                                w_state_nxt = ST_SWEEP;
            end
            ST_IDLE: begin
                w_sweep_nxt = '0;
                if (inv_all) w_state_nxt = ST_SWEEP;
                else         w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_SWEEP;
                w_sweep_nxt = '0;
            end
        endcase
    end

    // Output logic: busy plus same-cycle tag lookup
    always_comb begin
        w_busy    = (r_state == ST_SWEEP);
        w_active  = ~w_busy & ~flush & cached & sram_en;
        w_victim  = VW'(plru_victim(r_plru[w_index]));
        w_hit     = '0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_active && r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
                w_hit[w]  = 1'b1;
                w_hit_way = VW'(w);
            end else begin
                w_hit[w]  = 1'b0;
            end
        end
        w_miss = w_active & ~(|w_hit);
    end

    assign hit        = w_hit;
    assign miss       = w_miss;
    assign busy       = w_busy;
    assign stallreq   = w_miss | w_busy;
    assign victim     = w_victim;
    assign write_back = w_miss & r_valid[w_index][w_victim] & r_dirty[w_index][w_victim];
    assign axi_raddr  = cached ? {sram_addr[31:OFFSET_W], {OFFSET_W{1'b0}}} : sram_addr;
    assign axi_waddr  = {r_tag[w_index][w_victim], w_index, {OFFSET_W{1'b0}}};

    // Array update; contents are unreset because the sweep clears them before use
    always_ff @(posedge clk) begin
        if (r_state == ST_SWEEP) begin
            r_valid[r_sweep_cnt] <= '0;
            r_dirty[r_sweep_cnt] <= '0;
            r_plru[r_sweep_cnt]  <= '0;
        end else if (refresh && !inv_all) begin
            if ((|w_hit) && (|sram_wen)) r_dirty[w_index][w_hit_way] <= 1'b1;
            r_tag[w_index][w_victim]   <= w_tag;
            r_valid[w_index][w_victim] <= cached;
            r_dirty[w_index][w_victim] <= |sram_wen;
            r_plru[w_index]            <= plru_touch(r_plru[w_index], 2'(w_victim));
        end else if (|w_hit) begin
            r_plru[w_index] <= plru_touch(r_plru[w_index], 2'(w_hit_way));
            if (|sram_wen) r_dirty[w_index][w_hit_way] <= 1'b1;
        end
    end

endmodule

// File: doc/cache_tag_nway.md
CACHE_TAG_NWAY -- requirements
Module: cache_tag_nway

Interface
REQ-001 Parameter WAYS, default 4, meaning associativity; legal values 2 and 4.
REQ-002 Parameter INDEX_W, default 7, meaning set-index width; sets = 2^INDEX_W.
REQ-003 Parameter OFFSET_W, default 5, meaning line-offset width; TAG_W = 32-INDEX_W-OFFSET_W.
REQ-004 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 Port resetn, input, 1, reset, asynchronous and active-low.
REQ-006 Port flush, input, 1, pipeline flush; suppresses hit/miss/write_back.
REQ-007 Port cached, input, 1, access is cacheable.
REQ-008 Port sram_en, input, 1, access valid.
REQ-009 Port sram_wen, input, 4, byte write enables; nonzero = store.
REQ-010 Port sram_addr, input, 32, access address {tag,index,offset}.
REQ-011 Port refresh, input, 1, refill done; install tag in victim way.
REQ-012 Port inv_all, input, 1, start invalidate-all sweep.
REQ-013 Port hit, output, WAYS, one-hot hit vector.
REQ-014 Port miss, output, 1, cacheable access missed.
REQ-015 Port stallreq, output, 1, = miss | busy.
REQ-016 Port victim, output, log2(WAYS), way chosen for replacement at current index.
REQ-017 Port write_back, output, 1, victim line must be written back.
REQ-018 Port axi_raddr, output, 32, refill address.
REQ-019 Port axi_waddr, output, 32, write-back address {victim tag, index, OFFSET_W'b0}.
REQ-020 Port busy, output, 1, sweep in progress.

Function
REQ-021 Per set and way, the block SHALL store valid, dirty, tag[TAG_W-1:0]; per set, WAYS-1 PLRU bits.
REQ-022 FSM SHALL have states SWEEP and IDLE; SWEEP clears valid, dirty, PLRU of set sweep_cnt each cycle, sweep_cnt incrementing from 0.
REQ-023 SWEEP SHALL go to IDLE after clearing set 2^INDEX_W-1; sweep lasts exactly 2^INDEX_W cycles.
REQ-024 IDLE SHALL go to SWEEP with sweep_cnt=0 when inv_all=1; inv_all during SWEEP ignored (no restart).
REQ-025 busy SHALL be 1 exactly in SWEEP; hit=0, miss=0, write_back=0 while busy.
REQ-026 hit[w] SHALL be combinational, same cycle: ~busy & ~flush & cached & sram_en & valid[w] & tag[w]==addr tag.
REQ-027 miss SHALL = ~busy & ~flush & cached & sram_en & ~|hit.
REQ-028 Store hit (|hit & |sram_wen) SHALL set dirty of hit way at next edge.
REQ-029 PLRU SHALL be tree form: WAYS=2, bit0 = victim; WAYS=4, b0=0 selects ways0/1 (victim = b1), b0=1 selects ways2/3 (victim = 2+b2).
REQ-030 On hit or refresh to way w, PLRU bits on w's path SHALL be set to point away from w.
REQ-031 refresh in IDLE SHALL write into the victim way: tag=addr tag, valid=cached, dirty=|sram_wen; then update PLRU per REQ-030.
REQ-032 refresh in SWEEP, or coincident with inv_all, SHALL be ignored; inv_all has priority.
REQ-033 write_back SHALL = miss & valid[victim] & dirty[victim]; clean victims never write back.
REQ-034 axi_raddr SHALL = cached ? {addr[31:OFFSET_W], OFFSET_W'b0} : sram_addr.
REQ-035 Hit and refresh in the same cycle SHALL apply refresh's PLRU update only.

Reset
REQ-036 resetn=0 SHALL asynchronously force state SWEEP, sweep_cnt=0; outputs busy=1, stallreq=1, hit=0, miss=0, write_back=0.
REQ-037 Array contents need no reset; the post-reset sweep invalidates all sets before first access is served.
REQ-038 resetn asserted mid-sweep SHALL restart the sweep at set 0.

Verification
REQ-039 Release reset -> busy=1 for exactly 128 cycles (INDEX_W=7), then busy=0, stallreq=0 idle.
REQ-040 Load 0x1FC0_0040 cached -> miss=1, victim=0, write_back=0; refresh; same address -> hit=4'b0001, miss=0.
REQ-041 Refill four tags at index 2, store-hit way 1, touch ways 0,2,3; fifth tag -> victim=1, write_back=1, axi_waddr = way-1 tag,index 2,5'b0.
REQ-042 Cached load with flush=1 -> hit=0, miss=0, write_back=0, no state change.
REQ-043 inv_all with refresh same cycle -> no install; 128 cycles busy; prior hit address now misses.
REQ-044 Uncached load 0xBFAF_8004 -> miss=0, hit=0, axi_raddr=0xBFAF_8004.
